// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS phase sequencer and its quadrant decoder.
package dds_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LUT_ADDR_W = 6;
    localparam int QUAD_W     = 2;

    localparam logic [QUAD_W-1:0] QUAD_POS_RISE = 2'b00;
    localparam logic [QUAD_W-1:0] QUAD_POS_FALL = 2'b01;
    localparam logic [QUAD_W-1:0] QUAD_NEG_RISE = 2'b10;
    localparam logic [QUAD_W-1:0] QUAD_NEG_FALL = 2'b11;

endpackage

// File: rtl/dds_quadrant_decode.sv
// Splits the top phase bits into quarter-wave LUT address, descending flag and sign.
module dds_quadrant_decode
    import dds_pkg::*;
(
    input  logic [QUAD_W+LUT_ADDR_W-1:0] p,
    output logic [LUT_ADDR_W-1:0]        addr,
    output logic                         phase_pos,
    output logic                         sign_bit
);

    logic [QUAD_W-1:0] quad;

    assign quad = p[QUAD_W+LUT_ADDR_W-1 -: QUAD_W];
    assign addr = p[LUT_ADDR_W-1:0];

    always_comb begin
        phase_pos = 1'b0;
        sign_bit  = 1'b0;
        case (quad)
            QUAD_POS_RISE: begin phase_pos = 1'b0; sign_bit = 1'b0; end
            QUAD_POS_FALL: begin phase_pos = 1'b1; sign_bit = 1'b0; end
            QUAD_NEG_RISE: begin phase_pos = 1'b0; sign_bit = 1'b1; end
            QUAD_NEG_FALL: begin phase_pos = 1'b1; sign_bit = 1'b1; end
            default:       begin phase_pos = 1'b0; sign_bit = 1'b0; end
        endcase
    end

endmodule

// File: rtl/dds_tone_sequencer.sv
// Phase accumulator and burst controller feeding the quarter-wave sine datapath;
// tuning changes are deferred to a period boundary to keep the waveform glitch-free.
module dds_tone_sequencer
    import dds_pkg::*;
#(
    parameter int PHASE_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [PHASE_W-1:0]    cfg_step,
    input  logic [CNT_W-1:0]      cfg_periods,
    input  logic                  start,
    input  logic                  stop,
    output logic [LUT_ADDR_W-1:0] addr,
    output logic                  phase_pos,
    output logic                  sign_bit,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  period_tick,
    output logic                  done
);

    state_t               state, state_n;
    logic [PHASE_W-1:0]   phase;
    logic [PHASE_W-1:0]   step_active;
    logic [CNT_W-1:0]     periods_active;
    logic                 pend_valid;
    logic [PHASE_W-1:0]   pend_step;
    logic [CNT_W-1:0]     pend_periods;
    logic [CNT_W-1:0]     cnt;
    logic                 stop_req;

    logic                 running;
    logic [PHASE_W:0]     sum;
    logic                 wrap;
    logic                 xfer;
    logic [CNT_W-1:0]     target;
    logic [CNT_W:0]       cnt_inc;
    logic                 last_period;
    logic                 exit_run;
    logic [PHASE_W-1:0]   start_step;

    logic [LUT_ADDR_W-1:0] dec_addr;
    logic                  dec_pos;
    logic                  dec_sign;

    assign running   = (state == RUN);
    assign sum       = {1'b0, phase} + {1'b0, step_active};
    assign wrap      = running && sum[PHASE_W];
    assign cfg_ready = (state == IDLE) || (running && !pend_valid);
    assign xfer      = cfg_valid && cfg_ready;

    // A pending period count takes over as the target from the wrap that applies it.
    assign target      = pend_valid ? pend_periods : periods_active;
    assign cnt_inc     = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign last_period = (target != '0) && (cnt_inc == {1'b0, target});
    assign exit_run    = wrap && (last_period || stop_req || stop);
    assign start_step  = xfer ? cfg_step : step_active;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start && start_step != '0) state_n = RUN;
            RUN:     if (exit_run) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase          <= '0;
            step_active    <= '0;
            periods_active <= '0;
            pend_valid     <= 1'b0;
            pend_step      <= '0;
            pend_periods   <= '0;
            cnt            <= '0;
            stop_req       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    phase <= '0;
                    cnt   <= '0;
                    if (xfer) begin
                        step_active    <= cfg_step;
                        periods_active <= cfg_periods;
                    end
                end
                RUN: begin
                    phase <= sum[PHASE_W-1:0];
                    if (stop) stop_req <= 1'b1;
                    if (wrap) begin
                        // Saturate so a long continuous run never aliases onto a target.
                        cnt <= (&cnt) ? cnt : cnt_inc[CNT_W-1:0];
                        if (pend_valid) begin
                            step_active    <= pend_step;
                            periods_active <= pend_periods;
                            pend_valid     <= 1'b0;
                        end
                    end
                    if (xfer) begin
                        pend_valid   <= 1'b1;
                        pend_step    <= cfg_step;
                        pend_periods <= cfg_periods;
                    end
                end
                DONE: begin
                    phase    <= '0;
                    cnt      <= '0;
                    stop_req <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    dds_quadrant_decode u_decode (
        .p         (phase[PHASE_W-1 -: QUAD_W+LUT_ADDR_W]),
        .addr      (dec_addr),
        .phase_pos (dec_pos),
        .sign_bit  (dec_sign)
    );

    assign addr         = running ? dec_addr : '0;
    assign phase_pos    = running && dec_pos;
    assign sign_bit     = running && dec_sign;
    assign sample_valid = running;
    assign busy         = (state == RUN) || (state == DONE);
    assign period_tick  = wrap;
    assign done         = (state == DONE);

endmodule

// File: tb/tb_dds_tone_sequencer.sv
// Scoreboard bench: stimulus queues expected samples/done pulses, a negedge monitor checks them.
module tb_dds_tone_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_step;
    logic [15:0] cfg_periods;
    logic        start;
    logic        stop;
    logic [5:0]  addr;
    logic        phase_pos;
    logic        sign_bit;
    logic        sample_valid;
    logic        busy;
    logic        period_tick;
    logic        done;

    typedef struct packed {
        logic       sv;
        logic [5:0] addr;
        logic       pos;
        logic       sign;
        logic       tick;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_phase = 0;

    dds_tone_sequencer #(.PHASE_W(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_step     (cfg_step),
        .cfg_periods  (cfg_periods),
        .start        (start),
        .stop         (stop),
        .addr         (addr),
        .phase_pos    (phase_pos),
        .sign_bit     (sign_bit),
        .sample_valid (sample_valid),
        .busy         (busy),
        .period_tick  (period_tick),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (sample_valid || done) begin
            got = '{sv: sample_valid, addr: addr, pos: phase_pos, sign: sign_bit,
                    tick: period_tick, done: done};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, required nothing", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL sample_stream: got sv=%b addr=%0d pos=%b sign=%b tick=%b done=%b, required sv=%b addr=%0d pos=%b sign=%b tick=%b done=%b",
                             got.sv, got.addr, got.pos, got.sign, got.tick, got.done,
                             e.sv, e.addr, e.pos, e.sign, e.tick, e.done);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic push_samples(input int step, input int n);
        exp_t e;
        int   p;
        for (int i = 0; i < n; i++) begin
            p      = m_phase;
            e.sv   = 1'b1;
            e.addr = p[5:0];
            e.pos  = p[6];
            e.sign = p[7];
            e.tick = ((p + step) >= 256);
            e.done = 1'b0;
            exp_q.push_back(e);
            m_phase = (p + step) % 256;
        end
    endtask

    task automatic push_done();
        exp_t e;
        e      = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
        m_phase = 0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic send_cfg(input logic [7:0] s, input logic [15:0] n);
        cfg_valid   = 1'b1;
        cfg_step    = s;
        cfg_periods = n;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_step = '0; cfg_periods = '0;
        start = 1'b0; stop = 1'b0;
        repeat (2) tick();
        check("rst_outputs", {addr, phase_pos, sign_bit, sample_valid, busy, period_tick, done}, '0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        rst = 1'b0;
        tick();

        // 1: two periods at step 16
        send_cfg(8'd16, 16'd2);
        tick();
        cfg_valid = 1'b0;
        start = 1'b1;
        push_samples(16, 32);
        push_done();
        tick();
        start = 1'b0;
        drain("t1", 60);
        check("t1_busy_low", busy, 1'b0);

        // 2: continuous, stop mid-period finishes the period
        send_cfg(8'd16, 16'd0);
        tick();
        cfg_valid = 1'b0;
        start = 1'b1;
        push_samples(16, 16);
        push_done();
        tick();
        start = 1'b0;
        repeat (4) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain("t2", 40);
        check("t2_busy_low", busy, 1'b0);

        // 3: step change deferred to the wrap
        start = 1'b1;
        push_samples(16, 16);
        push_samples(32, 8);
        push_done();
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("t3_ready_before", cfg_ready, 1'b1);
        send_cfg(8'd32, 16'd0);
        tick();
        cfg_valid = 1'b0;
        check("t3_ready_low", cfg_ready, 1'b0);
        repeat (12) tick();
        check("t3_ready_low_s16", cfg_ready, 1'b0);
        check("t3_tick_s16", period_tick, 1'b1);
        tick();
        check("t3_ready_back", cfg_ready, 1'b1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        drain("t3", 40);
        check("t3_busy_low", busy, 1'b0);

        // 4: zero step blocks start; IDLE accepts config every cycle
        send_cfg(8'd0, 16'd0);
        check("t4_ready_a", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_busy", busy, 1'b0);
        check("t4_valid", sample_valid, 1'b0);
        send_cfg(8'd8, 16'd1);
        check("t4_ready_b", cfg_ready, 1'b1);
        tick();
        cfg_valid = 1'b0;

        // 5: non-divisor step, config and start together
        send_cfg(8'd24, 16'd1);
        start = 1'b1;
        push_samples(24, 11);
        push_done();
        tick();
        cfg_valid = 1'b0;
        start = 1'b0;
        drain("t5", 30);
        check("t5_busy_low", busy, 1'b0);

        // 6: reset mid-burst with pending config
        send_cfg(8'd16, 16'd0);
        tick();
        cfg_valid = 1'b0;
        start = 1'b1;
        push_samples(16, 7);
        tick();
        start = 1'b0;
        repeat (2) tick();
        send_cfg(8'd0, 16'd0);
        tick();
        cfg_valid = 1'b0;
        check("t6_pending_full", cfg_ready, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_phase = 0;
        check("t6_outputs", {addr, phase_pos, sign_bit, sample_valid, busy, period_tick, done}, '0);
        check("t6_cfg_ready", cfg_ready, 1'b1);
        check("t6_queue_empty", exp_q.size(), 0);
        tick();
        check("t6_no_done", done, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_start_ignored", busy, 1'b0);
        tick();
        check("t6_still_idle", sample_valid, 1'b0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_tone_sequencer.md
Name: dds_tone_sequencer

Overview:
Phase-accumulator controller that sequences the quarter-wave sine datapath.
- Holds a programmable frequency step and a burst length, both loaded through a valid/ready config port.
- Accumulates phase every clock while running. Decodes phase into the 6-bit quarter-wave LUT address, the descending-quadrant flag and the sign bit consumed by the DDS datapath.
- Step changes take effect only at a period boundary, so there are no waveform glitches.
- Reports busy, per-period tick and burst done.

Parameters:
PHASE_W, 8, accumulator width; top 8 bits form quadrant(2)+addr(6); legal range 8..32
CNT_W, 16, period-counter and burst-length width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  config offered
cfg_ready  out  1  config slot free
cfg_step  in  PHASE_W  phase increment per clock (tuning word)
cfg_periods  in  CNT_W  burst length in full periods; 0 = continuous
start  in  1  begin burst (level sampled per clock)
stop  in  1  request graceful stop at next period boundary
addr  out  6  quarter-wave LUT address
phase_pos  out  1  1 = descending quadrant (datapath uses 64-addr; addr 0 gives peak)
sign_bit  out  1  1 = negative half-cycle
sample_valid  out  1  addr/phase_pos/sign_bit valid this cycle
busy  out  1  high in RUN and DONE
period_tick  out  1  high during last sample of each period
done  out  1  one-cycle pulse at burst end

Behaviour:
- Reset state: IDLE; phase=0; step_active=0; periods_active=0; pending empty; cnt=0; stop_req=0.
- Outputs after reset: addr=0, phase_pos=0, sign_bit=0, sample_valid=0, busy=0, period_tick=0, done=0, cfg_ready=1.
- Reset mid-burst aborts in the same edge and produces no done pulse.
- Quadrant decode is combinational from registered phase p=phase[PHASE_W-1 -: 8]:
  - addr=p[5:0]; phase_pos=p[6]; sign_bit=p[7].
  - Q0 (00): rising. Q1 (01): descending; addr 0 means peak. Q2 (10): negative rising. Q3 (11): negative descending.
  - In IDLE and DONE the decode outputs are forced to 0.
- Config handshake: a transfer occurs when cfg_valid && cfg_ready.
  - IDLE: cfg_ready=1; a transfer loads step_active and periods_active directly.
  - RUN: a transfer writes a one-deep pending slot; cfg_ready=0 while the slot is full.
  - At wrap, pending moves to active and cfg_ready returns to 1 the next cycle.
  - The pending cfg_periods applies to the counter target from that wrap on; cnt is not reset.
- State IDLE:
  - start=1 && step_active!=0 -> RUN next cycle with phase=0, cnt=0.
  - start with step_active==0 is ignored.
  - stop is ignored in IDLE.
  - A cfg transfer and start in the same cycle: the new config is used for the burst.
- State RUN:
  - sample_valid=1.
  - Each clock: phase <= phase+step_active mod 2^PHASE_W. The residue is kept at wrap (phase continuity).
  - wrap = carry out of the add. period_tick=wrap (combinational).
  - On wrap: cnt<=cnt+1; pending applied if present.
  - Exit to DONE on wrap when (periods_active!=0 && cnt+1==periods_active) || stop_req || stop.
  - stop sets stop_req, which is held until exit. start is ignored in RUN.
- State DONE (1 cycle): done=1, busy=1, sample_valid=0; phase<=0, cnt<=0, stop_req<=0; then IDLE.
- cnt saturates at 2^CNT_W-1 in continuous mode; it never wraps into a false match.
- Latency: start at edge k gives the first sample (phase 0) in cycle k+1. Burst of N periods with step S (S divides 2^PHASE_W) gives exactly N*2^PHASE_W/S valid samples, then one done cycle.

Decomposition:
- Shared package dds_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - LUT_ADDR_W=6;
  - QUAD_W=2;
  - the quadrant encodings.
- Sub-module dds_quadrant_decode: combinational, p[7:0] -> addr, phase_pos, sign_bit. It is reused by any future multi-channel DDS.

Test Plan:
1. Reset, then step=16, periods=2, start -> 32 consecutive sample_valid cycles.
   - addr sequence per period: 0,16,32,48 repeated 4×.
   - phase_pos 0,0,0,0,1,1,1,1,… and sign_bit 0×8 then 1×8.
   - period_tick on samples 16 and 32; done on cycle 33; busy low on cycle 34.
2. step=16, periods=0 (continuous); at sample 5 assert stop for 1 cycle -> run continues to sample 16; tick and done follow; no samples after.
3. Running step=16 continuous; cfg step=32 at sample 3.
   - cfg_ready drops next cycle.
   - Samples 4–16 keep step 16.
   - The period after the wrap goes 0,32,64,… (8 samples per period).
   - cfg_ready re-asserts after the wrap.
4. step=0 then start -> stays IDLE, busy=0. A second cfg in IDLE is accepted immediately (cfg_ready=1 throughout).
5. step=24 (non-divisor), periods=1 -> first wrap at sample 11 (phase 240+24 -> 8); tick on sample 11; done next cycle.
6. rst asserted at sample 7 of a burst -> next cycle IDLE, all outputs 0, no done, pending cleared; a subsequent start with step_active 0 is ignored.
